// File: rtl/dmem_responder.sv
// Data-memory responder: byte-writable RAM with registered reads, plus an MMIO window with a
// console TX FIFO, its status register and a cycle counter. Optional macro: DMEM_BOUNDS_CHECK_EN.
module dmem_responder #(
    parameter int unsigned RAM_AW     = 12,
    parameter int unsigned FIFO_DEPTH = 16
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        dmem_en,
    input  logic [31:0] dmem_addr,
    input  logic [31:0] dmem_d,
    input  logic [3:0]  dmem_we,
    output logic [31:0] dmem_q,
    output logic        tx_valid,
    output logic [7:0]  tx_data,
    input  logic        tx_ready,
    output logic        bus_err
);

    localparam int unsigned PW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
    localparam int unsigned CW = $clog2(FIFO_DEPTH + 1);

    logic [31:0]       mem [2**RAM_AW];
    logic [7:0]        fifo_mem [FIFO_DEPTH];
    logic [PW-1:0]     wr_ptr_q, rd_ptr_q;
    logic [CW-1:0]     cnt_q;
    logic              ovf_q;
    logic [31:0]       cycle_q;
    logic [31:0]       rd_data;
    logic [RAM_AW-1:0] ram_idx;
    logic              is_ram, is_mmio, is_txdata, is_status;
    logic              acc_err;
    logic              full, empty, push, pop, push_ok, ovf_set, ovf_clr;
    logic [31:0]       status;

    assign ram_idx   = dmem_addr[RAM_AW+1:2];
    assign is_ram    = (dmem_addr[31:28] == 4'h0);
    assign is_mmio   = (dmem_addr[31:28] == 4'h8);
    assign is_txdata = is_mmio && (dmem_addr[27:0] == 28'h0);
    assign is_status = is_mmio && (dmem_addr[27:0] == 28'h4);

`ifdef DMEM_BOUNDS_CHECK_EN
    logic oob;
    logic bus_err_q;
    assign oob     = |(dmem_addr[27:0] >> (RAM_AW + 2));
    assign acc_err = (!is_ram && !is_mmio) || (is_ram && oob);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            bus_err_q <= 1'b0;
        end else if (dmem_en && acc_err) begin
            bus_err_q <= 1'b1;
        end
    end
    assign bus_err = bus_err_q;
`else
    assign acc_err = 1'b0;
    assign bus_err = 1'b0;
`endif

    assign full     = (cnt_q == CW'(FIFO_DEPTH));
    assign empty    = (cnt_q == '0);
    assign tx_valid = !empty;
    assign tx_data  = empty ? 8'h00 : fifo_mem[rd_ptr_q];
    assign status   = {16'h0, 8'(cnt_q), 5'h0, ovf_q, empty, full};

    // A push into a full FIFO survives only if the head leaves in the same cycle.
    always_comb begin
        push    = dmem_en && is_txdata && dmem_we[0];
        pop     = !empty && tx_ready;
        push_ok = push && (!full || pop);
        ovf_set = push && !push_ok;
        ovf_clr = dmem_en && is_status && dmem_we[0] && dmem_d[2];
    end

    always_comb begin
        rd_data = '0;
        if (is_ram) begin
            rd_data = mem[ram_idx];
        end else if (is_mmio) begin
            case (dmem_addr[27:0])
                28'h4:   rd_data = status;
                28'h8:   rd_data = cycle_q;
                default: rd_data = '0;
            endcase
        end
        if (acc_err) begin
            rd_data = 32'hDEAD_BEEF;
        end
    end

    // RAM contents are intentionally left out of reset.
    always_ff @(posedge clk) begin
        if (dmem_en && is_ram && !acc_err) begin
            for (int b = 0; b < 4; b++) begin
                if (dmem_we[b]) begin
                    mem[ram_idx][8*b +: 8] <= dmem_d[8*b +: 8];
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (push_ok) begin
            fifo_mem[wr_ptr_q] <= dmem_d[7:0];
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            dmem_q   <= '0;
            cycle_q  <= '0;
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            cnt_q    <= '0;
            ovf_q    <= 1'b0;
        end else begin
            cycle_q <= cycle_q + 32'd1;
            if (dmem_en) begin
                dmem_q <= rd_data;
            end
            if (push_ok) begin
                wr_ptr_q <= wr_ptr_q + PW'(1);
            end
            if (pop) begin
                rd_ptr_q <= rd_ptr_q + PW'(1);
            end
            if (push_ok && !pop) begin
                cnt_q <= cnt_q + CW'(1);
            end else if (pop && !push_ok) begin
                cnt_q <= cnt_q - CW'(1);
            end
            if (ovf_set) begin
                ovf_q <= 1'b1;
            end else if (ovf_clr) begin
                ovf_q <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_dmem_responder.sv
// Scoreboard bench for dmem_responder: read results and TX bytes are queued as expected at
// stimulus time and compared as the DUT produces them.
module tb_dmem_responder;

    localparam int DEPTH = 16;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        dmem_en;
    logic [31:0] dmem_addr;
    logic [31:0] dmem_d;
    logic [3:0]  dmem_we;
    logic [31:0] dmem_q;
    logic        tx_valid;
    logic [7:0]  tx_data;
    logic        tx_ready;
    logic        bus_err;

    int          checks = 0;
    int          errors = 0;
    int          pops   = 0;
    logic [31:0] rd_q[$];
    logic [7:0]  tx_m[$];
    logic        ovf_m  = 1'b0;
    logic [31:0] got, c1, c2;

    dmem_responder #(.RAM_AW(12), .FIFO_DEPTH(DEPTH)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .dmem_en   (dmem_en),
        .dmem_addr (dmem_addr),
        .dmem_d    (dmem_d),
        .dmem_we   (dmem_we),
        .dmem_q    (dmem_q),
        .tx_valid  (tx_valid),
        .tx_data   (tx_data),
        .tx_ready  (tx_ready),
        .bus_err   (bus_err)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s: got %08h expected %08h", tag, obs, exp);
        end
    endtask

    function automatic logic [31:0] status_exp();
        int n = tx_m.size();
        return {16'h0, 8'(n), 5'h0, ovf_m, (n == 0), (n == DEPTH)};
    endfunction

    // One strobe; if chk, the expected dmem_q is queued and compared the cycle after.
    task automatic bus(input logic [31:0] a, input logic [31:0] d, input logic [3:0] we,
                       input bit chk, input logic [31:0] exp, input string tag,
                       output logic [31:0] q);
        @(negedge clk);
        dmem_en = 1'b1; dmem_addr = a; dmem_d = d; dmem_we = we;
        if (chk) rd_q.push_back(exp);
        @(posedge clk);
        #1;
        dmem_en = 1'b0; dmem_we = 4'b0;
        q = dmem_q;
        if (chk) check(tag, dmem_q, rd_q.pop_front());
    endtask

    task automatic push_byte(input logic [7:0] b);
        logic [31:0] q;
        if (tx_m.size() < DEPTH) tx_m.push_back(b);
        else ovf_m = 1'b1;
        bus(32'h8000_0000, {24'h0, b}, 4'b0001, 1'b1, 32'h0, "txdata_rd", q);
    endtask

    always @(negedge clk) begin
        if (rst_n && tx_valid === 1'b1 && tx_ready) begin
            if (tx_m.size() == 0) check("tx_unexpected", 32'(tx_valid), 32'h0);
            else check("tx_data", {24'h0, tx_data}, {24'h0, tx_m.pop_front()});
            pops++;
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        rst_n = 1'b0; dmem_en = 1'b0; dmem_addr = '0; dmem_d = '0; dmem_we = '0;
        tx_ready = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk) rst_n = 1'b1;

        check("rst_dmem_q", dmem_q, 32'h0);
        check("rst_tx_valid", 32'(tx_valid), 32'h0);
        check("rst_tx_data", 32'(tx_data), 32'h0);
        check("rst_bus_err", 32'(bus_err), 32'h0);
        bus(32'h8000_0004, 0, 4'b0, 1'b1, 32'h2, "rst_status", got);

        // RAM byte enables and latency
        bus(32'h100, 32'h1234_5678, 4'b1111, 1'b0, 0, "", got);
        bus(32'h100, 0, 4'b0, 1'b1, 32'h1234_5678, "ram_rd", got);
        bus(32'h100, 32'hAB00_0000, 4'b1000, 1'b1, 32'h1234_5678, "ram_wr_old", got);
        bus(32'h100, 0, 4'b0, 1'b1, 32'hAB34_5678, "ram_byte", got);

        // read-first on same-word write
        bus(32'h200, 32'h11, 4'b1111, 1'b0, 0, "", got);
        bus(32'h200, 32'hFFFF_FFFF, 4'b1111, 1'b1, 32'h11, "rdw_old", got);
        bus(32'h200, 0, 4'b0, 1'b1, 32'hFFFF_FFFF, "rdw_new", got);

        // three bytes then drain
        push_byte(8'h41); push_byte(8'h42); push_byte(8'h43);
        bus(32'h8000_0004, 0, 4'b0, 1'b1, status_exp(), "status3", got);
        check("status3_const", got, 32'h0000_0300);
        pops = 0;
        tx_ready = 1'b1;
        repeat (6) @(posedge clk);
        #1 tx_ready = 1'b0;
        check("drain3_pops", pops, 3);
        check("drain3_valid", 32'(tx_valid), 32'h0);
        bus(32'h8000_0004, 0, 4'b0, 1'b1, 32'h2, "status_empty", got);

        // overflow
        for (int i = 0; i <= DEPTH; i++) push_byte(8'(8'h60 + i));
        bus(32'h8000_0004, 0, 4'b0, 1'b1, status_exp(), "status_ovf", got);
        check("status_ovf_const", got, 32'h0000_1005);
        bus(32'h8000_0004, 32'h4, 4'b0001, 1'b1, 32'h0000_1005, "ovf_clr_wr", got);
        ovf_m = 1'b0;
        bus(32'h8000_0004, 0, 4'b0, 1'b1, 32'h0000_1001, "status_clr", got);
        pops = 0;
        tx_ready = 1'b1;
        repeat (DEPTH + 4) @(posedge clk);
        #1 tx_ready = 1'b0;
        check("drain16_pops", pops, DEPTH);
        check("drain16_valid", 32'(tx_valid), 32'h0);

        // cycle counter
        bus(32'h8000_0008, 32'h5, 4'b1111, 1'b0, 0, "", c1);
        repeat (9) @(posedge clk);
        bus(32'h8000_0008, 0, 4'b0, 1'b0, 0, "", c2);
        check("cycle_delta", c2 - c1, 32'd10);

        // reset while draining
        push_byte(8'h51); push_byte(8'h52); push_byte(8'h53);
        bus(32'h100, 0, 4'b0, 1'b1, 32'hAB34_5678, "pre_rst_rd", got);
        tx_ready = 1'b1;
        @(negedge clk);
        @(posedge clk);
        #2 rst_n = 1'b0;
        tx_m.delete();
        #1;
        check("midrst_tx_valid", 32'(tx_valid), 32'h0);
        check("midrst_tx_data", 32'(tx_data), 32'h0);
        check("midrst_dmem_q", dmem_q, 32'h0);
        @(negedge clk);
        tx_ready = 1'b0;
        rst_n = 1'b1;
        bus(32'h8000_0004, 0, 4'b0, 1'b1, 32'h2, "post_rst_status", got);

`ifdef DMEM_BOUNDS_CHECK_EN
        bus(32'h4000_0000, 0, 4'b0, 1'b1, 32'hDEAD_BEEF, "unmapped_rd", got);
        check("bus_err_set", 32'(bus_err), 32'h1);
        bus(32'h0000_4100, 32'hCAFE_F00D, 4'b1111, 1'b1, 32'hDEAD_BEEF, "oob_wr", got);
        bus(32'h100, 0, 4'b0, 1'b1, 32'hAB34_5678, "oob_suppressed", got);
        repeat (3) @(posedge clk);
        #1 check("bus_err_sticky", 32'(bus_err), 32'h1);
`else
        bus(32'h4000_0000, 0, 4'b0, 1'b1, 32'h0, "unmapped_rd", got);
        check("bus_err_zero", 32'(bus_err), 32'h0);
        bus(32'h0000_4100, 32'hCAFE_F00D, 4'b1111, 1'b1, 32'hAB34_5678, "alias_wr", got);
        bus(32'h100, 0, 4'b0, 1'b1, 32'hCAFE_F00D, "alias_rd", got);
        check("bus_err_still_zero", 32'(bus_err), 32'h0);
`endif

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
